hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bus: D-instruction operand/destination info towards the
// scoreboard and the stall / busy / pending-count answers coming back.
interface hazard_scoreboard_if #(
   parameter int AW = 5,
   parameter int TW = 2
);
   logic          d_valid;
   logic [AW-1:0] d_rs;
   logic [AW-1:0] d_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic          d_wr_en;
   logic [AW-1:0] d_wr_addr;
   logic [TW-1:0] d_tnew;
   logic          d_md_start;
   logic          d_md_is_div;
   logic          d_md_use;
   logic          stall;
   logic          md_busy;
   logic [AW:0]   pend_cnt;

   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
             d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_is_div, d_md_use,
      input  stall, md_busy, pend_cnt
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
             d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_is_div, d_md_use,
      output stall, md_busy, pend_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks the remaining cycles until each GPR's
// newest in-flight result becomes forwardable, plus the multiply/divide unit
// occupancy, and stalls the D instruction when a source is not ready in time.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int TW       = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic                clk,
   input  logic                reset,
   hazard_scoreboard_if.slave  bus
);
   localparam int            MW       = $clog2(DIV_LAT + 1);
   localparam logic [TW-1:0] PEND_ONE = TW'(1'b1);
   localparam logic [MW-1:0] MD_ONE   = MW'(1'b1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);

   // Reject parameter sets the counters cannot represent.
   if (MULT_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
      $error("hazard_scoreboard: MULT_LAT and DIV_LAT must be nonzero");
   end
   if (MULT_LAT > (2 ** MW) - 1) begin : g_bad_mult
      $error("hazard_scoreboard: MULT_LAT does not fit the md counter");
   end
   if (TW < 1) begin : g_bad_tw
      $error("hazard_scoreboard: TW must be at least 1 so Tnew is representable");
   end
   if (NREG < 2 || (2 ** AW) < NREG) begin : g_bad_aw
      $error("hazard_scoreboard: AW too narrow for NREG");
   end

   logic [TW-1:0] pend_r     [NREG];
   logic [TW-1:0] pend_nxt_s [NREG];
   logic [MW-1:0] md_cnt_r;
   logic [MW-1:0] md_cnt_nxt_s;
   logic          md_busy_r;
   logic [AW:0]   pend_cnt_r;
   logic [AW:0]   pend_cnt_nxt_s;
   logic [TW-1:0] pend_rs_s;
   logic [TW-1:0] pend_rt_s;
   logic          haz_rs_s;
   logic          haz_rt_s;
   logic          haz_md_s;
   logic          stall_s;
   logic          issue_s;

   // Hazard detection from registered state and D inputs only.
   always_comb begin
      pend_rs_s = {TW{1'b0}};
      pend_rt_s = {TW{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         if (AW'(r) == bus.d_rs) begin
            pend_rs_s = pend_r[r];
         end else begin
            pend_rs_s = pend_rs_s;
         end
         if (AW'(r) == bus.d_rt) begin
            pend_rt_s = pend_r[r];
         end else begin
            pend_rt_s = pend_rt_s;
         end
      end
      // An all-ones Tuse can never be exceeded, so unused sources drop out.
      haz_rs_s = (bus.d_rs != {AW{1'b0}}) && (pend_rs_s > bus.d_tuse_rs);
      haz_rt_s = (bus.d_rt != {AW{1'b0}}) && (pend_rt_s > bus.d_tuse_rt);
      haz_md_s = (bus.d_md_start | bus.d_md_use) & md_busy_r;
      stall_s  = bus.d_valid & (haz_rs_s | haz_rt_s | haz_md_s);
      issue_s  = bus.d_valid & ~stall_s;
   end

   // Next pending table: age every entry, newest issuing producer overrides.
   always_comb begin
      pend_cnt_nxt_s = {(AW + 1){1'b0}};
      for (int r = 0; r < NREG; r++) begin
         if (r == 0) begin
            pend_nxt_s[r] = {TW{1'b0}};
         end else if (issue_s && bus.d_wr_en && (AW'(r) == bus.d_wr_addr)) begin
            pend_nxt_s[r] = bus.d_tnew;
         end else if (pend_r[r] != {TW{1'b0}}) begin
            pend_nxt_s[r] = pend_r[r] - PEND_ONE;
         end else begin
            pend_nxt_s[r] = {TW{1'b0}};
         end
         if (pend_nxt_s[r] != {TW{1'b0}}) begin
            pend_cnt_nxt_s = pend_cnt_nxt_s + CNT_ONE;
         end else begin
            pend_cnt_nxt_s = pend_cnt_nxt_s;
         end
      end
   end

   // Next multiply/divide occupancy count.
   always_comb begin
      md_cnt_nxt_s = {MW{1'b0}};
      if (issue_s && bus.d_md_start) begin
         md_cnt_nxt_s = bus.d_md_is_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
      end else if (md_cnt_r != {MW{1'b0}}) begin
         md_cnt_nxt_s = md_cnt_r - MD_ONE;
      end else begin
         md_cnt_nxt_s = {MW{1'b0}};
      end
   end

   // State registers; reset clears everything without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            pend_r[r] <= {TW{1'b0}};
         end
         md_cnt_r   <= {MW{1'b0}};
         md_busy_r  <= 1'b0;
         pend_cnt_r <= {(AW + 1){1'b0}};
      end else begin
         for (int r = 0; r < NREG; r++) begin
            pend_r[r] <= pend_nxt_s[r];
         end
         md_cnt_r   <= md_cnt_nxt_s;
         md_busy_r  <= (md_cnt_nxt_s != {MW{1'b0}});
         pend_cnt_r <= pend_cnt_nxt_s;
      end
   end

   assign bus.stall    = stall_s;
   assign bus.md_busy  = md_busy_r;
   assign bus.pend_cnt = pend_cnt_r;
endmodule
